// File: rtl/mk14_vdu_pkg.sv
// mk14_vdu_pkg: display-memory constants and grant encoding shared by mk14_soc,
// vdu_vga_600p and the display RAM arbiter.
package mk14_vdu_pkg;
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_VDU} grant_t;
    localparam int VDU_BASE_ADDR = 'h0200;
    localparam int VDU_DEPTH = 512;
    localparam logic [7:0] VDU_SPACE = 8'h20;
endpackage

// File: rtl/vdu_req_latch.sv
// vdu_req_latch: one-deep pending VDU fetch register; a strobe that lands on a
// still-waiting request replaces it and raises a sticky overrun flag.
module vdu_req_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_strobe,
    input  logic [15:0] i_addr,
    input  logic        i_grant,
    output logic        o_pending,
    output logic [15:0] o_addr,
    output logic        o_overrun
);
    logic        r_pending;
    logic [15:0] r_addr;
    logic        r_overrun;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_strobe) begin
                r_addr    <= i_addr;
                r_overrun <= r_overrun | (r_pending & ~i_grant);
            end
            r_pending <= i_strobe | (r_pending & ~i_grant);
        end
    end
    assign o_pending = r_pending;
    assign o_addr    = r_addr;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/vdu_ram_arbiter.sv
// vdu_ram_arbiter: shares the single-port display RAM between the CPU bus and
// the VDU fetcher; VDU has priority, a starvation counter bounds CPU wait.
module vdu_ram_arbiter
    import mk14_vdu_pkg::*;
#(
    parameter int BASE_ADDR  = VDU_BASE_ADDR,
    parameter int DEPTH      = VDU_DEPTH,
    parameter int AW         = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          vdu_read_en,
    input  logic [15:0]   vdu_addr,
    output logic [7:0]    vdu_data_out,
    output logic          vdu_valid,
    output logic          vdu_overrun,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic          w_vpend;
    logic [15:0]   w_vaddr;
    logic          w_voverrun;
    logic          w_cpu_req;
    logic          w_vdu_req;
    logic          w_gnt_cpu;
    logic          w_gnt_vdu;
    logic [16:0]   w_coff;
    logic [16:0]   w_voff;
    logic          w_cpu_in;
    logic          w_vdu_in;
    grant_t        r_gnt;
    logic          r_oor;
    logic          r_we;
    logic [SW-1:0] r_starve;

    vdu_req_latch u_latch (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (vdu_read_en),
        .i_addr   (vdu_addr),
        .i_grant  (w_gnt_vdu),
        .o_pending(w_vpend),
        .o_addr   (w_vaddr),
        .o_overrun(w_voverrun)
    );

    // A held cpu_req is masked while its ack is on the bus so it is not re-granted.
    assign w_cpu_req = cpu_req & (r_gnt != GNT_CPU) & ~rst;
    assign w_vdu_req = w_vpend & ~rst;
    assign w_gnt_cpu = w_cpu_req & (~w_vdu_req | (r_starve == SW'(STARVE_MAX)));
    assign w_gnt_vdu = w_vdu_req & ~w_gnt_cpu;

    // Widened subtraction: addresses below the base wrap to large values and fail the range test.
    assign w_coff   = {1'b0, cpu_addr} - 17'(BASE_ADDR);
    assign w_voff   = {1'b0, w_vaddr} - 17'(BASE_ADDR);
    assign w_cpu_in = w_coff < 17'(DEPTH);
    assign w_vdu_in = w_voff < 17'(DEPTH);

    assign ram_en    = w_gnt_cpu ? w_cpu_in : (w_gnt_vdu & w_vdu_in);
    assign ram_we    = w_gnt_cpu & w_cpu_in & cpu_we;
    assign ram_addr  = w_gnt_cpu ? w_coff[AW-1:0] : (w_gnt_vdu ? w_voff[AW-1:0] : '0);
    assign ram_wdata = ram_we ? cpu_wdata : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt    <= GNT_NONE;
            r_oor    <= 1'b0;
            r_we     <= 1'b0;
            r_starve <= '0;
        end else begin
            r_gnt    <= w_gnt_cpu ? GNT_CPU : (w_gnt_vdu ? GNT_VDU : GNT_NONE);
            r_oor    <= w_gnt_cpu ? ~w_cpu_in : ~w_vdu_in;
            r_we     <= w_gnt_cpu & cpu_we;
            r_starve <= w_gnt_cpu ? '0 :
                        (w_cpu_req && r_starve != SW'(STARVE_MAX)) ? r_starve + SW'(1) : r_starve;
        end
    end

    // Responses are gated by rst so an in-flight result never escapes a reset.
    assign cpu_ack      = ~rst & (r_gnt == GNT_CPU);
    assign cpu_rdata    = (cpu_ack & ~r_we) ? (r_oor ? 8'hFF : ram_rdata) : 8'h00;
    assign vdu_valid    = ~rst & (r_gnt == GNT_VDU);
    assign vdu_data_out = vdu_valid ? (r_oor ? VDU_SPACE : ram_rdata) : 8'h00;
    assign vdu_overrun  = ~rst & w_voverrun;
endmodule

// File: tb/tb_vdu_ram_arbiter.sv
// tb_vdu_ram_arbiter: directed checks of reset, CPU/VDU access, out-of-range
// decode, starvation, collision ordering and mid-operation reset.
module tb_vdu_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        vdu_read_en;
    logic [15:0] vdu_addr;
    logic [7:0]  vdu_data_out;
    logic        vdu_valid;
    logic        vdu_overrun;
    logic        ram_en;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  mem [512];
    int          checks = 0;
    int          errors = 0;

    vdu_ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .vdu_read_en (vdu_read_en),
        .vdu_addr    (vdu_addr),
        .vdu_data_out(vdu_data_out),
        .vdu_valid   (vdu_valid),
        .vdu_overrun (vdu_overrun),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Read-first synchronous single-port RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0205; cpu_wdata = 8'h00;
        vdu_read_en = 1'b1; vdu_addr = 16'h0205;
        #2;
        chk("rst_ram_en_a", 16'(ram_en), 16'h0);
        chk("rst_ack_a", 16'(cpu_ack), 16'h0);
        chk("rst_valid_a", 16'(vdu_valid), 16'h0);
        @(negedge clk);
        chk("rst_ram_en_b", 16'(ram_en), 16'h0);
        chk("rst_ack_b", 16'(cpu_ack), 16'h0);
        chk("rst_valid_b", 16'(vdu_valid), 16'h0);
        cyc(); rst = 1'b0; cpu_req = 1'b0; vdu_read_en = 1'b0;
        @(negedge clk);
        chk("post_ram_en", 16'(ram_en), 16'h0);
        chk("post_ram_we", 16'(ram_we), 16'h0);
        chk("post_ram_addr", 16'(ram_addr), 16'h0);
        chk("post_ram_wdata", 16'(ram_wdata), 16'h0);
        chk("post_ack", 16'(cpu_ack), 16'h0);
        chk("post_rdata", 16'(cpu_rdata), 16'h0);
        chk("post_valid", 16'(vdu_valid), 16'h0);
        chk("post_vdata", 16'(vdu_data_out), 16'h0);
        chk("post_overrun", 16'(vdu_overrun), 16'h0);
        // CPU write 0x0205 <- A5
        cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0205; cpu_wdata = 8'hA5;
        @(negedge clk);
        chk("wr_ram_en", 16'(ram_en), 16'h1);
        chk("wr_ram_we", 16'(ram_we), 16'h1);
        chk("wr_ram_addr", 16'(ram_addr), 16'h005);
        chk("wr_ram_wdata", 16'(ram_wdata), 16'hA5);
        chk("wr_no_ack_yet", 16'(cpu_ack), 16'h0);
        cyc(); cpu_we = 1'b0;
        @(negedge clk);
        chk("wr_ack", 16'(cpu_ack), 16'h1);
        chk("ack_cycle_masked", 16'(ram_en), 16'h0);
        cyc();
        @(negedge clk);
        chk("rd_ram_en", 16'(ram_en), 16'h1);
        chk("rd_ram_we", 16'(ram_we), 16'h0);
        chk("rd_ram_addr", 16'(ram_addr), 16'h005);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_ack", 16'(cpu_ack), 16'h1);
        chk("rd_data", 16'(cpu_rdata), 16'hA5);
        // Out-of-range CPU read
        cyc(); cpu_req = 1'b1; cpu_addr = 16'h0100;
        @(negedge clk);
        chk("oor_cpu_ram_en", 16'(ram_en), 16'h0);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        chk("oor_cpu_ack", 16'(cpu_ack), 16'h1);
        chk("oor_cpu_data", 16'(cpu_rdata), 16'hFF);
        // Out-of-range VDU fetch
        cyc(); vdu_read_en = 1'b1; vdu_addr = 16'h0400;
        @(negedge clk);
        chk("oor_vdu_valid_early", 16'(vdu_valid), 16'h0);
        cyc(); vdu_read_en = 1'b0;
        @(negedge clk);
        chk("oor_vdu_ram_en", 16'(ram_en), 16'h0);
        cyc();
        @(negedge clk);
        chk("oor_vdu_valid", 16'(vdu_valid), 16'h1);
        chk("oor_vdu_data", 16'(vdu_data_out), 16'h20);
        // In-range VDU fetch of the byte the CPU wrote
        cyc(); vdu_read_en = 1'b1; vdu_addr = 16'h0205;
        cyc(); vdu_read_en = 1'b0;
        @(negedge clk);
        chk("vdu_ram_en", 16'(ram_en), 16'h1);
        chk("vdu_ram_addr", 16'(ram_addr), 16'h005);
        cyc();
        @(negedge clk);
        chk("vdu_valid", 16'(vdu_valid), 16'h1);
        chk("vdu_data", 16'(vdu_data_out), 16'hA5);
        chk("no_overrun_yet", 16'(vdu_overrun), 16'h0);
        // Starvation: VDU strobed every cycle, CPU joins one cycle later
        cyc(); vdu_read_en = 1'b1; vdu_addr = 16'h0210;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 1) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0205; end
            if (k == 6) cpu_req = 1'b0;
            @(negedge clk);
            if (k <= 4) chk($sformatf("starve_vdu_gnt%0d", k), 16'(ram_addr), 16'h010);
            if (k == 4) chk("starve_no_overrun", 16'(vdu_overrun), 16'h0);
            if (k == 5) chk("starve_cpu_gnt", 16'(ram_addr), 16'h005);
            if (k == 6) begin
                chk("starve_ack", 16'(cpu_ack), 16'h1);
                chk("starve_ack_data", 16'(cpu_rdata), 16'hA5);
                chk("starve_overrun", 16'(vdu_overrun), 16'h1);
            end
        end
        cyc(); vdu_read_en = 1'b0;
        cyc(); cyc();
        // Collision: seed RAM[0x010]=11, then VDU fetch races a CPU write of 22
        cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0210; cpu_wdata = 8'h11;
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        chk("seed_ack", 16'(cpu_ack), 16'h1);
        cyc(); vdu_read_en = 1'b1; vdu_addr = 16'h0210;
        cyc(); vdu_read_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0210; cpu_wdata = 8'h22;
        @(negedge clk);
        chk("coll_vdu_first", 16'(ram_we), 16'h0);
        chk("coll_vdu_addr", 16'(ram_addr), 16'h010);
        cyc();
        @(negedge clk);
        chk("coll_old_valid", 16'(vdu_valid), 16'h1);
        chk("coll_old_data", 16'(vdu_data_out), 16'h11);
        chk("coll_cpu_write", 16'(ram_we), 16'h1);
        cyc(); cpu_req = 1'b0; vdu_read_en = 1'b1;
        @(negedge clk);
        chk("coll_cpu_ack", 16'(cpu_ack), 16'h1);
        cyc(); vdu_read_en = 1'b0;
        cyc();
        @(negedge clk);
        chk("coll_new_valid", 16'(vdu_valid), 16'h1);
        chk("coll_new_data", 16'(vdu_data_out), 16'h22);
        // Reset in the response cycle of a CPU read
        cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0205;
        @(negedge clk);
        chk("mid_grant", 16'(ram_en), 16'h1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("mid_no_ack", 16'(cpu_ack), 16'h0);
        chk("mid_no_ram_en", 16'(ram_en), 16'h0);
        chk("mid_overrun_clr", 16'(vdu_overrun), 16'h0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("mid_no_ack_after", 16'(cpu_ack), 16'h0);
        chk("mid_regrant", 16'(ram_en), 16'h1);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_reissue_ack", 16'(cpu_ack), 16'h1);
        chk("mid_reissue_data", 16'(cpu_rdata), 16'hA5);
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vdu_ram_arbiter.md
Name: vdu_ram_arbiter

Overview:
- Shares one single-port synchronous display RAM between two requesters: the MK14 CPU bus (read/write) and the VDU character fetcher (read only).
- Sits between mk14_soc's display-memory window and vdu_vga_600p. Both are in the same clock domain; the requester clocks are synchronised upstream.
- VDU fetches have priority. A bounded starvation counter guarantees the CPU forward progress.

Parameters:
- BASE_ADDR, 'h0200, absolute address of display RAM byte 0.
- DEPTH, 512, display RAM size in bytes (power of two).
- AW, 9, RAM address width; must equal log2(DEPTH).
- STARVE_MAX, 4, CPU wait cycles after which the CPU is granted ahead of a pending VDU request.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  16  absolute CPU address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data; valid in the cpu_ack cycle
- cpu_ack  out  1  one-cycle completion pulse
- vdu_read_en  in  1  one-cycle fetch strobe
- vdu_addr  in  16  absolute fetch address
- vdu_data_out  out  8  fetched byte; valid while vdu_valid is high
- vdu_valid  out  1  one-cycle data-valid pulse
- vdu_overrun  out  1  sticky flag: a VDU strobe arrived while one was still pending
- ram_en  out  1  RAM cycle enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM word address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data; one-cycle latency after ram_en

Behaviour:
Clock and reset:
- One clock domain. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- On reset: all outputs are 0, the pending VDU request is cleared, the starvation counter is 0, the grant register is NONE and vdu_overrun is 0.

VDU request capture:
- vdu_read_en loads a one-deep pending register with vdu_addr.
- If the register is already pending and not granted in that cycle, the new address overwrites it and vdu_overrun sets.

Address decode:
- offset = addr − BASE_ADDR. The address is in range when 0 ≤ offset < DEPTH; ram_addr = offset[AW-1:0].
- Out-of-range CPU access: no RAM cycle. cpu_ack is asserted the next cycle, with cpu_rdata = 8'hFF for reads; writes are dropped.
- Out-of-range VDU fetch: no RAM cycle. vdu_valid is asserted the next cycle with data 8'h20 (space).

Arbitration, evaluated every cycle on the pending VDU request and cpu_req (when not already acked):
- If only one requester is present, it is granted.
- If both are present, VDU is granted unless starve_cnt == STARVE_MAX, in which case the CPU is granted.
- The granted requester drives ram_en/ram_we/ram_addr/ram_wdata combinationally in the grant cycle.
- The grant register (NONE / CPU / VDU) is captured for the response cycle.

Starvation counter:
- Increments, saturating at STARVE_MAX, on each cycle the CPU is requesting but not granted.
- Clears on a CPU grant.

Response cycle (grant cycle + 1):
- Grant was CPU: cpu_ack = 1, and cpu_rdata = ram_rdata for reads.
- Grant was VDU: vdu_valid = 1 and vdu_data_out = ram_rdata.

CPU re-request:
- cpu_req is masked for the cycle in which its ack is being returned, so a held request is not re-granted.
- Issue rate is therefore one CPU access every two cycles at most. The VDU can be granted on consecutive cycles.

Latency and throughput:
- Minimum latency is 1 cycle (request edge to ack/valid).
- Sustained throughput is one RAM access per cycle.

Ordering of a same-address collision:
- The order follows the grant order. A VDU read granted before a CPU write returns the old byte. One granted after it returns the new byte.

Reset mid-operation:
- An in-flight response is discarded: no ack or valid is issued after reset.
- The CPU must re-issue its request.

Decomposition:
- Package mk14_vdu_pkg holds:
  - typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_VDU} grant_t
  - the constants VDU_BASE_ADDR = 'h0200, VDU_DEPTH = 512 and VDU_SPACE = 8'h20, shared with vdu_vga_600p and mk14_soc.
- One sub-module is natural: vdu_req_latch, the one-deep pending register with overrun detection.
- Arbitration, decode and the response pipeline stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles while cpu_req=1 and vdu_read_en=1 → no ram_en, ack or valid during reset. All outputs are 0 on the first cycle after rst falls.
- CPU write then read: write 'h0205 ← 8'hA5, then read 'h0205 → ram_addr=9'h005, ram_we=1 on the write grant. The read returns cpu_rdata=8'hA5 with cpu_ack 1 cycle after grant.
- Out of range:
  - CPU read 'h0100 → ram_en stays 0; cpu_ack the next cycle with cpu_rdata=8'hFF.
  - VDU fetch 'h0400 → vdu_valid the next cycle with data 8'h20.
- Priority and starvation: with STARVE_MAX=4, hold cpu_req and strobe VDU every cycle for 10 cycles → the first 4 grants go to VDU and the 5th goes to CPU. VDU strobes lost meanwhile set vdu_overrun.
- Collision: with RAM[0x010]=8'h11, the CPU writes 'h0210 ← 8'h22 in the same cycle as a VDU fetch of 'h0210 → VDU is granted first and returns 8'h11. A subsequent fetch returns 8'h22.
- Reset mid-operation: assert rst in the cycle after a CPU read grant → no cpu_ack is issued. A re-issued read completes normally with correct data.
